// File: rtl/uart_rx_os_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and bit-timing helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_state_e;

   localparam int UART_DATA_BITS = 8;

   // Mid-bit position used as the centre of the three-point majority window.
   function automatic int half_bit(input int cpb);
      return cpb / 2;
   endfunction

endpackage

// File: rtl/uart_rx_os_bit_sync.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset value.
module bit_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver: synchronised input, three-point majority sampling around mid-bit,
// stop-bit framing check and one-cycle byte / framing-error strobes.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int H  = half_bit(CLKS_PER_BIT);
   localparam int CW = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] K_A    = CW'(H - 1);
   localparam logic [CW-1:0] K_B    = CW'(H);
   localparam logic [CW-1:0] K_C    = CW'(H + 1);
   localparam logic [CW-1:0] K_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

   uart_state_e                state;
   logic                       rx_s;
   logic [CW-1:0]              cnt;
   logic [2:0]                 bit_idx;
   logic [UART_DATA_BITS-1:0]  shreg;
   logic                       s_a;
   logic                       s_b;
   logic                       maj;

   bit_sync #(.RESET_VAL(1'b1)) u_rx_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // The third sample is the live rx_s, so the vote is meaningful only at k = H+1.
   always_comb begin
      maj = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
   end

   assign busy = (state != IDLE);

   // Receiver FSM. IDLE holds the counter at 0 so the first low cycle is count 0 of the
   // start bit; STOP returns to IDLE right after the vote so a back-to-back start is not missed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         s_a        <= 1'b1;
         s_b        <= 1'b1;
         data       <= 8'h00;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;

         if (cnt == K_A) s_a <= rx_s;
         if (cnt == K_B) s_b <= rx_s;

         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               if (!rx_s) begin
                  state <= START;
                  cnt   <= CW'(1);
               end
            end

            START: begin
               if (cnt == K_C && maj) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == K_LAST) begin
                  state <= DATA;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DATA: begin
               if (cnt == K_C) shreg[bit_idx] <= maj;
               if (cnt == K_LAST) begin
                  cnt <= '0;
                  if (bit_idx == LAST_BIT) begin
                     state   <= STOP;
                     bit_idx <= '0;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            STOP: begin
               if (cnt == K_C) begin
                  cnt <= '0;
                  if (maj) begin
                     data       <= shreg;
                     data_valid <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            // A line stuck low must return high before another frame can start.
            BREAK: begin
               cnt <= '0;
               if (rx_s) state <= IDLE;
            end

            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os at CLKS_PER_BIT = 8: frames, false start, framing
// error with line break, majority glitch rejection, back-to-back frames and mid-frame reset.
module tb_uart_rx_os;

   localparam int C = 8;
   localparam int H = C / 2;
   localparam int STROBE_OFS = 9 * C + H + 2;

   typedef struct {
      bit         err;
      logic [7:0] d;
      int         cyc;
   } ev_t;

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   int         check_count;
   int         error_count;
   int         cyc;
   logic       busy_smp;
   logic [7:0] last_good;
   ev_t        exp_q[$];
   ev_t        obs_q[$];

   uart_rx_os #(.CLKS_PER_BIT(C)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .data       (data),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock cycle: drive rx just after the rising edge, sample outputs on the falling edge.
   task automatic tick(input logic v);
      ev_t o;
      @(posedge clk);
      cyc++;
      #1 rx = v;
      @(negedge clk);
      busy_smp = busy;
      if (data_valid || frame_err) begin
         o.err = frame_err;
         o.d   = data;
         o.cyc = cyc;
         obs_q.push_back(o);
         if (data_valid && frame_err) begin
            check_count++;
            error_count++;
            $display("[TB] FAIL strobe_exclusive: data_valid and frame_err both high at cycle %0d", cyc);
         end
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit,
                                input int glitch_j, input int abort_j);
      ev_t e;
      logic v;
      if (abort_j < 0) begin
         e.err = !stop_bit;
         e.d   = stop_bit ? b : last_good;
         e.cyc = cyc + 1 + 2 + STROBE_OFS;
         exp_q.push_back(e);
         if (stop_bit) last_good = b;
      end
      for (int j = 0; j < 10; j++) begin
         for (int k = 0; k < C; k++) begin
            if (j == 0)      v = 1'b0;
            else if (j == 9) v = stop_bit;
            else             v = b[j-1];
            if (j == glitch_j && k == H) v = ~v;
            tick(v);
            if (j == abort_j && k == 2) begin
               rst = 1'b1;
               #1;
               check_count++;
               if (data !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
                  error_count++;
                  $display("[TB] FAIL midframe_reset_outputs: data=%h dv=%b fe=%b busy=%b, want 00 0 0 0",
                           data, data_valid, frame_err, busy);
               end
               #1 rst = 1'b0;
               rx = 1'b1;
               return;
            end
         end
      end
   endtask

   task automatic checkOutput(input string name);
      ev_t e;
      ev_t o;
      for (int w = 0; w < 400 && obs_q.size() < exp_q.size(); w++) tick(1'b1);
      for (int w = 0; w < 20; w++) tick(1'b1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_count++;
         if (obs_q.size() == 0) begin
            error_count++;
            $display("[TB] FAIL %s_missing: no strobe, want err=%0d data=%h at cycle %0d",
                     name, e.err, e.d, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.err !== e.err || o.d !== e.d || o.cyc !== e.cyc) begin
               error_count++;
               $display("[TB] FAIL %s_strobe: got err=%0d data=%h cycle=%0d, want err=%0d data=%h cycle=%0d",
                        name, o.err, o.d, o.cyc, e.err, e.d, e.cyc);
            end
         end
      end
      check_count++;
      if (obs_q.size() != 0) begin
         error_count++;
         $display("[TB] FAIL %s_extra: %0d unexpected strobes, want 0", name, obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx  = 1'b1;
      for (int i = 0; i < 3; i++) tick(1'b1);
      check_count++;
      if (data !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
         error_count++;
         $display("[TB] FAIL reset_outputs: data=%h dv=%b fe=%b busy=%b, want 00 0 0 0",
                  data, data_valid, frame_err, busy);
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick(1'b1);
      obs_q.delete();
   endtask

   task automatic test_valid_frame();
      applyStimulus(8'hA5, 1'b1, -1, -1);
      checkOutput("frame_a5");
   endtask

   task automatic test_false_start();
      int t0;
      t0 = cyc + 1 + 2;
      for (int i = 0; i < 14; i++) begin
         tick((i < 2) ? 1'b0 : 1'b1);
         if (cyc >= t0 + 1 && cyc <= t0 + 5) begin
            check_count++;
            if (busy_smp !== 1'b1) begin
               error_count++;
               $display("[TB] FAIL false_start_busy_hi: busy=%b at t0+%0d, want 1", busy_smp, cyc - t0);
            end
         end else if (cyc >= t0 + 6) begin
            check_count++;
            if (busy_smp !== 1'b0) begin
               error_count++;
               $display("[TB] FAIL false_start_busy_lo: busy=%b at t0+%0d, want 0", busy_smp, cyc - t0);
            end
         end
      end
      checkOutput("false_start");
   endtask

   task automatic test_frame_error();
      applyStimulus(8'h3C, 1'b0, -1, -1);
      for (int i = 0; i < 30; i++) tick(1'b0);
      check_count++;
      if (busy_smp !== 1'b1) begin
         error_count++;
         $display("[TB] FAIL break_hold_busy: busy=%b while line low, want 1", busy_smp);
      end
      for (int i = 0; i < 4; i++) tick(1'b1);
      check_count++;
      if (busy_smp !== 1'b0) begin
         error_count++;
         $display("[TB] FAIL break_release_busy: busy=%b after line high, want 0", busy_smp);
      end
      checkOutput("frame_err_3c");
      applyStimulus(8'h81, 1'b1, -1, -1);
      checkOutput("after_break_81");
   endtask

   task automatic test_glitch();
      applyStimulus(8'h00, 1'b1, 4, -1);
      checkOutput("glitch_00");
   endtask

   task automatic test_back_to_back();
      applyStimulus(8'h00, 1'b1, -1, -1);
      applyStimulus(8'hFF, 1'b1, -1, -1);
      checkOutput("b2b");
   endtask

   task automatic test_midframe_reset();
      applyStimulus(8'h96, 1'b1, -1, 5);
      for (int i = 0; i < 120; i++) tick(1'b1);
      checkOutput("aborted_frame");
      applyStimulus(8'h5A, 1'b1, -1, -1);
      checkOutput("after_reset_5a");
   endtask

   initial begin
      check_count = 0;
      error_count = 0;
      cyc         = 0;
      busy_smp    = 1'b0;
      last_good   = 8'h00;
      rst         = 1'b1;
      rx          = 1'b1;
      test_reset();
      test_valid_frame();
      test_false_start();
      test_frame_error();
      test_glitch();
      test_back_to_back();
      test_midframe_reset();
      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
